// File: rtl/alu_issue_stage.sv
// Operand-issue and writeback stage wrapped around an external 72-bit registered ALU.
// Optional feature macro: ALU_ISSUE_DIV0_EN (drop divide-by-zero ops and raise div0_err).
module alu_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_op,
  input  logic [3:0]  in_rd,
  input  logic [3:0]  in_rs1,
  input  logic [3:0]  in_rs2,
  input  logic [54:0] in_imm,
  output logic [3:0]  alu_op,
  output logic [71:0] alu_a,
  output logic [71:0] alu_b,
  input  logic [71:0] alu_c,
  output logic        wb_valid,
  output logic [3:0]  wb_rd,
  output logic [71:0] wb_data,
  input  logic [3:0]  dbg_addr,
  output logic [71:0] dbg_data,
  output logic        div0_err
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  typedef struct packed {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [54:0] imm;
  } instr_t;

  // Handshake: an instruction transfers on any edge where in_valid && in_ready;
  // in_valid may be held while in_ready is low and nothing is taken.
  instr_t         r_fifo [DEPTH];
  logic [PW-1:0]  r_wr_ptr;
  logic [PW-1:0]  r_rd_ptr;
  logic [CW-1:0]  r_count;

  logic [71:0]    r_rf [16];

  logic           r_s1_valid;
  logic [3:0]     r_s1_rd;
  logic           r_s2_valid;
  logic [3:0]     r_s2_rd;

  logic [3:0]     r_alu_op;
  logic [71:0]    r_alu_a;
  logic [71:0]    r_alu_b;

  logic           w_full;
  logic           w_empty;
  logic           w_push;
  logic           w_pop;
  logic           w_issue;
  logic           w_div0;
  logic           w_hazard;
  logic           w_head_is_imm;
  instr_t         w_head;
  logic [71:0]    w_rs1_val;
  logic [71:0]    w_rs2_val;
  logic [71:0]    w_b_sel;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !rst && !w_full;
  assign w_push   = in_valid && in_ready;

  assign w_head        = r_fifo[r_rd_ptr];
  assign w_head_is_imm = (w_head.op == 4'd5) || (w_head.op == 4'd6) ||
                         (w_head.op == 4'd7) || (w_head.op == 4'd15);

  assign wb_valid = r_s2_valid && (r_s2_rd != 4'd0);
  assign wb_rd    = r_s2_rd;
  assign wb_data  = alu_c;

  // Write-through reads: the value being written back this cycle wins over the array.
  assign w_rs1_val = (w_head.rs1 == 4'd0) ? 72'd0 :
                     (wb_valid && (wb_rd == w_head.rs1)) ? alu_c : r_rf[w_head.rs1];
  assign w_rs2_val = (w_head.rs2 == 4'd0) ? 72'd0 :
                     (wb_valid && (wb_rd == w_head.rs2)) ? alu_c : r_rf[w_head.rs2];
  assign dbg_data  = (dbg_addr == 4'd0) ? 72'd0 :
                     (wb_valid && (wb_rd == dbg_addr)) ? alu_c : r_rf[dbg_addr];

  assign w_b_sel = w_head_is_imm ? {17'd0, w_head.imm} : w_rs2_val;

  // Only the instruction in s1 can be unready; s2 results arrive via write-through.
  assign w_hazard = !w_empty && r_s1_valid && (r_s1_rd != 4'd0) &&
                    ((w_head.rs1 == r_s1_rd) ||
                     (!w_head_is_imm && (w_head.rs2 == r_s1_rd)));

  assign w_pop   = !w_empty && !w_hazard;
  assign w_issue = w_pop && !w_div0;

`ifdef ALU_ISSUE_DIV0_EN
  logic r_div0_err;

  assign w_div0   = w_pop && (w_head.op == 4'd3) && (w_b_sel == 72'd0);
  assign div0_err = r_div0_err;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_div0_err <= 1'b0;
    end else if (w_div0) begin
      r_div0_err <= 1'b1;
    end
  end
`else
  assign w_div0   = 1'b0;
  assign div0_err = 1'b0;
`endif

  // FIFO storage carries no reset; occupancy is tracked by the pointers alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wr_ptr] <= '{op: in_op, rd: in_rd, rs1: in_rs1, rs2: in_rs2, imm: in_imm};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_rd    <= 4'd0;
      r_s2_valid <= 1'b0;
      r_s2_rd    <= 4'd0;
      r_alu_op   <= 4'd0;
      r_alu_a    <= 72'd0;
      r_alu_b    <= 72'd0;
    end else begin
      r_s2_valid <= r_s1_valid;
      r_s2_rd    <= r_s1_rd;
      r_s1_valid <= w_issue;
      r_s1_rd    <= w_issue ? w_head.rd : 4'd0;
      if (w_issue) begin
        r_alu_op <= w_head.op;
        r_alu_a  <= w_rs1_val;
        r_alu_b  <= w_b_sel;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        r_rf[i] <= 72'd0;
      end
    end else if (wb_valid) begin
      r_rf[wb_rd] <= alu_c;
    end
  end

  assign alu_op = r_alu_op;
  assign alu_a  = r_alu_a;
  assign alu_b  = r_alu_b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Self-checking bench for alu_issue_stage: models the external registered ALU,
// drives a vector table plus hand-written corner sequences, scoreboards writebacks.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_op, in_rd, in_rs1, in_rs2;
  logic [54:0] in_imm;
  logic [3:0]  alu_op;
  logic [71:0] alu_a, alu_b, alu_c;
  logic        wb_valid;
  logic [3:0]  wb_rd;
  logic [71:0] wb_data;
  logic [3:0]  dbg_addr;
  logic [71:0] dbg_data;
  logic        div0_err;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit saw_full;

  logic [75:0] exp_q[$];
  int          wb_cyc_q[$];

  typedef struct {
    logic [3:0]  op;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [54:0] imm;
    logic [71:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  addr;
    logic [71:0] val;
  } reg_chk_t;

  vec_t     vecs[$];
  reg_chk_t finals[$];

  alu_issue_stage #(.DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_c(alu_c),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data), .div0_err(div0_err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [71:0] alu_fn(input logic [3:0] op, input logic [71:0] a,
                                         input logic [71:0] b);
    case (op)
      4'd0:    return a + b;
      4'd1:    return a - b;
      4'd2:    return a * b;
      4'd3:    return (b == 72'd0) ? {72{1'b1}} : a / b;
      4'd4:    return a & b;
      4'd5:    return a + b;
      4'd6:    return a | b;
      4'd7:    return a ^ b;
      4'd8:    return a | b;
      4'd9:    return a ^ b;
      4'd10:   return a << b[6:0];
      4'd11:   return {71'd0, a == b};
      4'd12:   return {71'd0, a < b};
      4'd13:   return {71'd0, a != b};
      4'd14:   return {71'd0, a >= b};
      default: return a - b;
    endcase
  endfunction

  // External registered ALU
  always @(posedge clk) begin
    if (rst) alu_c <= 72'd0;
    else     alu_c <= alu_fn(alu_op, alu_a, alu_b);
  end

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Writeback monitor and scoreboard
  always @(negedge clk) begin
    if (!rst) begin
      if (!in_ready) saw_full = 1'b1;
      if (wb_valid) begin
        logic [75:0] e;
        wb_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          check("wb_unexpected", {68'd0, wb_rd}, 72'd0);
        end else begin
          e = exp_q.pop_front();
          check("wb_rd", {68'd0, wb_rd}, {68'd0, e[75:72]});
          check("wb_data", wb_data, e[71:0]);
        end
      end
    end
  end

  task automatic push(input logic [3:0] op, input logic [3:0] rd, input logic [3:0] rs1,
                      input logic [3:0] rs2, input logic [54:0] imm,
                      input logic [71:0] exp, input bit expect_wb);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("push_accept", {71'd0, in_ready}, 72'd1);
    @(posedge clk);
    if (expect_wb && rd != 4'd0) exp_q.push_back({rd, exp});
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check("drain", 72'(exp_q.size()), 72'd0);
    exp_q.delete();
    wait_cycles(3);
  endtask

  task automatic check_reg(input string name, input logic [3:0] addr, input logic [71:0] exp);
    dbg_addr = addr;
    @(negedge clk);
    check(name, dbg_data, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [71:0] exp_r6;
    logic [71:0] exp_div0;

    vecs.push_back('{4'd5,  4'd4,  4'd1, 4'd0,  55'd5,   72'd15});
    vecs.push_back('{4'd0,  4'd5,  4'd1, 4'd2,  55'd0,   72'd30});
    vecs.push_back('{4'd1,  4'd6,  4'd2, 4'd1,  55'd0,   72'd10});
    vecs.push_back('{4'd2,  4'd7,  4'd4, 4'd2,  55'd0,   72'd300});
    vecs.push_back('{4'd3,  4'd8,  4'd7, 4'd4,  55'd0,   72'd20});
    vecs.push_back('{4'd4,  4'd9,  4'd5, 4'd4,  55'd0,   72'd14});
    vecs.push_back('{4'd6,  4'd10, 4'd1, 4'd0,  55'd5,   72'd15});
    vecs.push_back('{4'd7,  4'd11, 4'd10, 4'd0, 55'hF,   72'd0});
    vecs.push_back('{4'd8,  4'd12, 4'd1, 4'd9,  55'd0,   72'd14});
    vecs.push_back('{4'd9,  4'd13, 4'd5, 4'd2,  55'd0,   72'd10});
    vecs.push_back('{4'd10, 4'd14, 4'd1, 4'd6,  55'd0,   72'd10240});
    vecs.push_back('{4'd11, 4'd4,  4'd6, 4'd1,  55'd0,   72'd1});
    vecs.push_back('{4'd12, 4'd5,  4'd1, 4'd2,  55'd0,   72'd1});
    vecs.push_back('{4'd13, 4'd6,  4'd1, 4'd1,  55'd0,   72'd0});
    vecs.push_back('{4'd14, 4'd7,  4'd2, 4'd1,  55'd0,   72'd1});
    vecs.push_back('{4'd15, 4'd8,  4'd2, 4'd0,  55'd25,  72'hFF_FFFF_FFFF_FFFF_FFFB});
    vecs.push_back('{4'd5,  4'd9,  4'd0, 4'd0,  55'h7F_FFFF_FFFF_FFFF, 72'h7F_FFFF_FFFF_FFFF});
    vecs.push_back('{4'd0,  4'd10, 4'd9, 4'd9,  55'd0,   72'hFF_FFFF_FFFF_FFFE});
    vecs.push_back('{4'd1,  4'd11, 4'd0, 4'd1,  55'd0,   72'hFF_FFFF_FFFF_FFFF_FFF6});
    vecs.push_back('{4'd0,  4'd12, 4'd0, 4'd11, 55'd0,   72'hFF_FFFF_FFFF_FFFF_FFF6});

    finals.push_back('{4'd4,  72'd1});
    finals.push_back('{4'd9,  72'h7F_FFFF_FFFF_FFFF});
    finals.push_back('{4'd12, 72'hFF_FFFF_FFFF_FFFF_FFF6});
    finals.push_back('{4'd13, 72'd10});
    finals.push_back('{4'd14, 72'd10240});

    rst = 1'b1; in_valid = 1'b1; in_op = 4'd5; in_rd = 4'd1; in_rs1 = 4'd0; in_rs2 = 4'd0;
    in_imm = 55'd1; dbg_addr = 4'd1; saw_full = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", {71'd0, in_ready}, 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("rst_alu_op", {68'd0, alu_op}, 72'd0);
    check("rst_alu_a", alu_a, 72'd0);
    check("rst_alu_b", alu_b, 72'd0);
    check("rst_wb_valid", {71'd0, wb_valid}, 72'd0);
    check("rst_wb_rd", {68'd0, wb_rd}, 72'd0);
    check("rst_div0", {71'd0, div0_err}, 72'd0);
    check("rst_reg", dbg_data, 72'd0);
    check("ready_after_rst", {71'd0, in_ready}, 72'd1);
    @(posedge clk);
    #1;

    // Push-to-write latency of an independent instruction
    push(4'd5, 4'd1, 4'd0, 4'd0, 55'd7, 72'd7, 1'b1);
    @(negedge clk);
    check("lat_t0_wb", {71'd0, wb_valid}, 72'd0);
    @(negedge clk);
    check("lat_t1_op", {68'd0, alu_op}, 72'd5);
    check("lat_t1_a", alu_a, 72'd0);
    check("lat_t1_b", alu_b, 72'd7);
    check("lat_t1_wb", {71'd0, wb_valid}, 72'd0);
    @(negedge clk);
    check("lat_t2_wb", {71'd0, wb_valid}, 72'd1);
    check("lat_t2_rd", {68'd0, wb_rd}, 72'd1);
    @(negedge clk);
    check("lat_t3_reg", dbg_data, 72'd7);
    check("lat_t3_wb", {71'd0, wb_valid}, 72'd0);
    @(posedge clk);
    #1;

    // Dependent pair: one bubble
    wb_cyc_q.delete();
    push(4'd5, 4'd1, 4'd0, 4'd0, 55'd3, 72'd3, 1'b1);
    push(4'd0, 4'd2, 4'd1, 4'd1, 55'd0, 72'd6, 1'b1);
    drain();
    check("dep_wb_count", 72'(wb_cyc_q.size()), 72'd2);
    check("dep_gap", 72'(wb_cyc_q[1] - wb_cyc_q[0]), 72'd2);
    check_reg("dep_r2", 4'd2, 72'd6);

    // Independent pair: back-to-back
    wb_cyc_q.delete();
    push(4'd5, 4'd1, 4'd0, 4'd0, 55'd10, 72'd10, 1'b1);
    push(4'd5, 4'd2, 4'd0, 4'd0, 55'd20, 72'd20, 1'b1);
    drain();
    check("b2b_wb_count", 72'(wb_cyc_q.size()), 72'd2);
    check("b2b_gap", 72'(wb_cyc_q[1] - wb_cyc_q[0]), 72'd1);

    // Write to R0 is discarded
    wb_cyc_q.delete();
    push(4'd5, 4'd0, 4'd0, 4'd0, 55'd9, 72'd9, 1'b1);
    wait_cycles(6);
    check("r0_no_wb", 72'(wb_cyc_q.size()), 72'd0);
    check_reg("r0_reads_zero", 4'd0, 72'd0);

    // Vector table, pushed back-to-back
    for (int i = 0; i < vecs.size(); i++) begin
      push(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].exp, 1'b1);
    end
    drain();
    for (int i = 0; i < finals.size(); i++) begin
      check_reg($sformatf("table_r%0d", finals[i].addr), finals[i].addr, finals[i].val);
    end

    // Dependent chain on R3 stalls pops long enough to fill the FIFO
    saw_full = 1'b0;
    push(4'd5, 4'd3, 4'd0, 4'd0, 55'd1, 72'd1, 1'b1);
    for (int i = 1; i < 10; i++) begin
      push(4'd0, 4'd3, 4'd3, 4'd3, 55'd0, 72'd1 << i, 1'b1);
    end
    drain();
    check("full_seen", {71'd0, saw_full}, 72'd1);
    check_reg("chain_r3", 4'd3, 72'd512);

    // Divide by zero
`ifdef ALU_ISSUE_DIV0_EN
    exp_r6   = 72'd55;
    exp_div0 = 72'd1;
`else
    exp_r6   = {72{1'b1}};
    exp_div0 = 72'd0;
`endif
    push(4'd5, 4'd5, 4'd0, 4'd0, 55'd100, 72'd100, 1'b1);
    push(4'd5, 4'd6, 4'd0, 4'd0, 55'd55, 72'd55, 1'b1);
    push(4'd3, 4'd6, 4'd5, 4'd15, 55'd0, {72{1'b1}}, (exp_div0 == 72'd0));
    drain();
    check_reg("div0_r6", 4'd6, exp_r6);
    check("div0_flag", {71'd0, div0_err}, exp_div0);
    wait_cycles(5);
    check("div0_sticky", {71'd0, div0_err}, exp_div0);

    // Reset while instructions are queued and in flight
    wb_cyc_q.delete();
    push(4'd5, 4'd9, 4'd0, 4'd0, 55'd77, 72'd77, 1'b0);
    push(4'd5, 4'd10, 4'd0, 4'd0, 55'd88, 72'd88, 1'b0);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {71'd0, in_ready}, 72'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    wait_cycles(6);
    check("midrst_no_wb", 72'(wb_cyc_q.size()), 72'd0);
    check("midrst_div0", {71'd0, div0_err}, 72'd0);
    check_reg("midrst_r9", 4'd9, 72'd0);
    check_reg("midrst_r10", 4'd10, 72'd0);
    check_reg("midrst_r8", 4'd8, 72'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    n_fail++;
    $display("FAIL global_timeout: simulation did not complete (cycle %0d)", cyc);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Operand-issue and writeback stage wrapped around the 72-bit registered ALU. It buffers decoded instructions in a small FIFO and reads operands from an internal 16 x 72-bit register file. It drives the ALU's op/A/B inputs, tracks in-flight instructions, and writes the ALU's registered result C back to the register file. A one-cycle read-after-write hazard is resolved by stalling issue.

## Interface
- DEPTH, 4: instruction FIFO entries (power of two, >= 2)
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  FIFO can accept; equals !full, forced 0 while rst=1
- in_op  in  4  ALU opcode, 0-15
- in_rd  in  4  destination register
- in_rs1  in  4  source register for A
- in_rs2  in  4  source register for B (ignored for immediate ops)
- in_imm  in  55  immediate for ops 5, 6, 7, 15
- alu_op  out  4  registered opcode to ALU
- alu_a  out  72  registered operand A
- alu_b  out  72  registered operand B
- alu_c  in  72  ALU registered result
- wb_valid  out  1  writeback occurs at the next edge
- wb_rd  out  4  writeback destination
- wb_data  out  72  writeback data (= alu_c)
- dbg_addr  in  4  debug register-file read address
- dbg_data  out  72  combinational read of R[dbg_addr], write-through applied
- div0_err  out  1  sticky divide-by-zero flag (see Configuration)

## Operation
- Push on in_valid & in_ready. Pop = issue of the FIFO head. Pointers wrap modulo DEPTH. Push and pop in the same cycle are legal when not full.
- R0 reads as 0. Writes to R0 are discarded. R0 never causes a hazard.
- Operand A = R[rs1]. Operand B = {17'b0, imm} for ops 5, 6, 7, 15; otherwise R[rs2].
- Register-file read is write-through: a read of the address being written this cycle returns wb_data.
- Pipeline tags:
  - s1 = instruction issued at the last edge, which the ALU samples next edge.
  - s2 = instruction whose result is on alu_c.
  - At every edge: s2 <= s1; s1 <= issued-or-bubble.
- Hazard: the head reads a nonzero register equal to s1.rd while s1 is valid. The rs2 check applies only to non-immediate ops. On a hazard the head stalls one cycle. s2 hazards are covered by write-through.
- Issue condition: FIFO non-empty and no hazard. On issue, alu_op/alu_a/alu_b load the new values. On a bubble they hold their previous values.
- wb_valid = s2.valid & (s2.rd != 0). R[s2.rd] <= alu_c at the following edge.
- All 16 opcodes pass through unmodified, including compare ops 11-14, whose 0/1 result is written to rd.

## Timing
- Reset: FIFO empty; s1 and s2 invalid; alu_op=0, alu_a=0, alu_b=0; all registers 0; wb_valid=0, wb_rd=0; div0_err=0.
- Independent instruction, pushed at edge T0:
  - Issued at T1.
  - ALU samples at T2.
  - wb_valid high during T2-T3.
  - Register written at T3.
  - Total: 3 cycles push-to-write.
- Throughput: 1 instruction/cycle when independent. A back-to-back dependency costs exactly one bubble.
- Full FIFO: in_ready=0; in_valid is ignored.
- Reset asserted mid-operation: in-flight s1/s2 results are discarded with no register write, and the FIFO is flushed at that edge.

## Configuration
- ALU_ISSUE_DIV0_EN defined:
  - A head with op=3 and selected B==0 is popped without issuing. It becomes a bubble in s1, and rd is unchanged.
  - div0_err is set and stays 1 until rst.
- Not defined: op 3 issues normally regardless of B, and div0_err is tied 0.

## Test plan
- Reset, then push R1 = 0+imm via op 5, imm=7 (rs1=0) -> wb_valid at T2 with wb_rd=1, wb_data=7; after T3, dbg_data at dbg_addr=1 reads 7.
- Push op 5 to R1 (imm=3), then op 0 with rd=2, rs1=1, rs2=1 on consecutive cycles -> one bubble between issues; R2=6.
- Push two independent op 5s (rd=1 and rd=2) back-to-back -> issues on consecutive edges, no bubble.
- Hold pops stalled via a dependent chain and push 6 instructions -> in_ready=0 after the FIFO holds 4; nothing lost or reordered; final register values match in-order execution.
- Push op 5 with rd=0, imm=9 -> wb_valid stays 0; R0 reads 0.
- With ALU_ISSUE_DIV0_EN: op 3 with R[rs2]=0 -> no issue, rd unchanged, div0_err=1 until rst. Without it: issues, and div0_err remains 0.
